// File: rtl/ripple_count_reader_if.sv
// Bus between a ripple counter consumer and its users: raw counter bits and
// clear go in, the accepted code, its step and the running total come out.
interface ripple_count_reader_if #(
    parameter int TOTAL_WIDTH = 16
);
    logic [3:0]             count_in;
    logic                   clear;
    logic                   valid;
    logic [3:0]             value;
    logic [3:0]             delta;
    logic [TOTAL_WIDTH-1:0] total;
    logic                   overflow;
    logic                   skip;

    modport master (
        output count_in, clear,
        input  valid, value, delta, total, overflow, skip
    );

    modport slave (
        input  count_in, clear,
        output valid, value, delta, total, overflow, skip
    );
endinterface

// File: rtl/ripple_count_reader.sv
// Synchronous reader for an asynchronous 4-bit ripple counter. Synchronizes the
// raw bits, waits for the code to settle, and reports every settled change as a
// modulo-16 step accumulated into a wrapping total with sticky overflow/skip.
module ripple_count_reader #(
    parameter int STABLE_CYCLES = 2,
    parameter int TOTAL_WIDTH   = 16,
    parameter int MAX_STEP      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ripple_count_reader_if.slave bus
);
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [3:0] RUN_MAX    = 4'(STABLE_CYCLES);
    localparam logic [3:0] STEP_LIMIT = (MAX_STEP > 15) ? 4'd15 : 4'(MAX_STEP);

    logic [3:0]             s1_r, s2_r, cand_r, run_r;
    logic [1:0]             prime_r;
    state_t                 state_r, state_nx_s;
    logic                   valid_r, valid_nx_s;
    logic [3:0]             value_r, value_nx_s;
    logic [3:0]             delta_r, delta_nx_s;
    logic [TOTAL_WIDTH-1:0] total_r, total_nx_s;
    logic                   overflow_r, overflow_nx_s;
    logic                   skip_r, skip_nx_s;
    logic [3:0]             run_nx_s;
    logic [3:0]             step_s;
    logic [TOTAL_WIDTH:0]   sum_s;
    logic                   primed_s;
    logic                   accept_s;

    // The zeros loaded by reset are not a counter code: a baseline may only be
    // taken once cand holds a genuine sample, three edges after release.
    assign primed_s = (prime_r == 2'd3);
    assign step_s   = cand_r - value_r;
    assign sum_s    = {1'b0, total_r} + {{(TOTAL_WIDTH - 3){1'b0}}, step_s};
    assign accept_s = (run_r == RUN_MAX) && primed_s &&
                      ((state_r == ST_INIT) || (cand_r != value_r));

    // Saturating stability run length for the current candidate.
    always_comb begin
        run_nx_s = 4'd0;
        if (s2_r == cand_r) begin
            if (run_r >= RUN_MAX) begin
                run_nx_s = RUN_MAX;
            end else begin
                run_nx_s = run_r + 4'd1;
            end
        end else begin
            run_nx_s = 4'd0;
        end
    end

    // Two-flop synchronizer, candidate register, run counter and priming count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r    <= 4'd0;
            s2_r    <= 4'd0;
            cand_r  <= 4'd0;
            run_r   <= 4'd0;
            prime_r <= 2'd0;
        end else begin
            s1_r    <= bus.count_in;
            s2_r    <= s1_r;
            cand_r  <= s2_r;
            run_r   <= run_nx_s;
            prime_r <= primed_s ? 2'd3 : (prime_r + 2'd1);
        end
    end

    // Next state and next output values; clear overrides the accumulators.
    always_comb begin
        state_nx_s    = state_r;
        valid_nx_s    = 1'b0;
        value_nx_s    = value_r;
        delta_nx_s    = delta_r;
        total_nx_s    = total_r;
        overflow_nx_s = overflow_r;
        skip_nx_s     = skip_r;
        case (state_r)
            ST_INIT: begin
                if (accept_s) begin
                    value_nx_s = cand_r;
                    state_nx_s = ST_TRACK;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_TRACK: begin
                if (accept_s) begin
                    valid_nx_s = 1'b1;
                    value_nx_s = cand_r;
                    delta_nx_s = step_s;
                    total_nx_s = sum_s[TOTAL_WIDTH-1:0];
                    if (sum_s[TOTAL_WIDTH]) begin
                        overflow_nx_s = 1'b1;
                    end else begin
                        overflow_nx_s = overflow_r;
                    end
                    if (step_s > STEP_LIMIT) begin
                        skip_nx_s = 1'b1;
                    end else begin
                        skip_nx_s = skip_r;
                    end
                end else begin
                    state_nx_s = ST_TRACK;
                end
            end
            default: begin
                state_nx_s = ST_INIT;
            end
        endcase
        if (bus.clear) begin
            total_nx_s    = {TOTAL_WIDTH{1'b0}};
            overflow_nx_s = 1'b0;
            skip_nx_s     = 1'b0;
        end else begin
            total_nx_s    = total_nx_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            valid_r    <= 1'b0;
            value_r    <= 4'd0;
            delta_r    <= 4'd0;
            total_r    <= {TOTAL_WIDTH{1'b0}};
            overflow_r <= 1'b0;
            skip_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            valid_r    <= valid_nx_s;
            value_r    <= value_nx_s;
            delta_r    <= delta_nx_s;
            total_r    <= total_nx_s;
            overflow_r <= overflow_nx_s;
            skip_r     <= skip_nx_s;
        end
    end

    assign bus.valid    = valid_r;
    assign bus.value    = value_r;
    assign bus.delta    = delta_r;
    assign bus.total    = total_r;
    assign bus.overflow = overflow_r;
    assign bus.skip     = skip_r;
endmodule

// File: tb/tb_ripple_count_reader.sv
// Scoreboard bench for ripple_count_reader (STABLE_CYCLES 2, TOTAL_WIDTH 4,
// MAX_STEP 4). Stimulus pushes hand-computed expectations; a negedge monitor
// pops them when valid pulses, and also services immediate state checks.
module tb_ripple_count_reader;
    typedef struct packed {
        logic        v;
        logic [3:0]  value;
        logic [3:0]  delta;
        logic [3:0]  total;
        logic        ovf;
        logic        skip;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        done;
    logic [31:0] cyc;
    int          n_checks;
    int          n_fail;
    exp_t        exp_q[$];
    string       exp_name_q[$];
    exp_t        dir_q[$];
    string       dir_name_q[$];
    exp_t        e;
    string       nm;

    ripple_count_reader_if #(.TOTAL_WIDTH(4)) bus();

    ripple_count_reader #(
        .STABLE_CYCLES(2),
        .TOTAL_WIDTH  (4),
        .MAX_STEP     (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic exp_t mk(input logic v, input logic [3:0] value, input logic [3:0] delta,
                                input logic [3:0] total, input logic ovf, input logic skip,
                                input logic [31:0] c);
        exp_t r;
        r.v = v; r.value = value; r.delta = delta; r.total = total;
        r.ovf = ovf; r.skip = skip; r.cyc = c;
        return r;
    endfunction

    task automatic drive(input logic [3:0] code);
        @(posedge clk);
        #1;
        bus.count_in = code;
    endtask

    // Change the code and expect one valid six edges later.
    task automatic step(input logic [3:0] code, input logic [3:0] d, input logic [3:0] t,
                        input logic o, input logic s, input string name);
        drive(code);
        exp_q.push_back(mk(1'b1, code, d, t, o, s, cyc + 32'd6));
        exp_name_q.push_back(name);
        repeat (8) @(posedge clk);
    endtask

    task automatic check_now(input logic [3:0] value, input logic [3:0] d, input logic [3:0] t,
                             input logic o, input logic s, input string name);
        dir_q.push_back(mk(1'b0, value, d, t, o, s, 32'd0));
        dir_name_q.push_back(name);
    endtask

    // Reset with a code held, then let the baseline settle and check it.
    task automatic do_reset(input logic [3:0] code, input string name);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.count_in = code;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_now(code, 4'd0, 4'd0, 1'b0, 1'b0, name);
    endtask

    // Monitor: pops the scoreboard on every valid pulse and serves direct checks.
    always @(negedge clk) begin
        if (bus.valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got valid value=%0d delta=%0d at cycle %0d, required no valid",
                         bus.value, bus.delta, cyc);
            end else begin
                e  = exp_q.pop_front();
                nm = exp_name_q.pop_front();
                if (bus.value !== e.value || bus.delta !== e.delta || bus.total !== e.total ||
                    bus.overflow !== e.ovf || bus.skip !== e.skip || cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got value=%0d delta=%0d total=%0d ovf=%0b skip=%0b cyc=%0d, required value=%0d delta=%0d total=%0d ovf=%0b skip=%0b cyc=%0d",
                             nm, bus.value, bus.delta, bus.total, bus.overflow, bus.skip, cyc,
                             e.value, e.delta, e.total, e.ovf, e.skip, e.cyc);
                end
            end
        end
        if (dir_q.size() != 0) begin
            e  = dir_q.pop_front();
            nm = dir_name_q.pop_front();
            n_checks++;
            if (bus.valid !== e.v || bus.value !== e.value || bus.delta !== e.delta ||
                bus.total !== e.total || bus.overflow !== e.ovf || bus.skip !== e.skip) begin
                n_fail++;
                $display("FAIL %s: got valid=%0b value=%0d delta=%0d total=%0d ovf=%0b skip=%0b, required valid=%0b value=%0d delta=%0d total=%0d ovf=%0b skip=%0b",
                         nm, bus.valid, bus.value, bus.delta, bus.total, bus.overflow, bus.skip,
                         e.v, e.value, e.delta, e.total, e.ovf, e.skip);
            end
        end
        if (done) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_valid: got %0d expected responses never seen, required 0", exp_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 32'd0;
        done         = 1'b0;
        reset        = 1'b1;
        bus.count_in = 4'd0;
        bus.clear    = 1'b0;
        #2;
        check_now(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "reset_state");

        // Baseline after reset: no valid, value 5, total 0.
        do_reset(4'd5, "baseline_5");

        // Single step 0 -> 1.
        do_reset(4'd0, "baseline_0");
        step(4'd1, 4'd1, 4'd1, 1'b0, 1'b0, "single_step");

        // Ripple glitches 6, 4, 0 held one clock each, then 8.
        do_reset(4'd7, "baseline_7");
        drive(4'd6);
        drive(4'd4);
        drive(4'd0);
        step(4'd8, 4'd1, 4'd1, 1'b0, 1'b0, "glitch_reject");

        // Wrap 14 -> 15 -> 0, then jump 0 -> 9 beyond MAX_STEP.
        do_reset(4'd14, "baseline_14");
        step(4'd15, 4'd1, 4'd1, 1'b0, 1'b0, "wrap_to_15");
        step(4'd0,  4'd1, 4'd2, 1'b0, 1'b0, "wrap_15_to_0");
        step(4'd9,  4'd9, 4'd11, 1'b0, 1'b1, "skip_jump_9");

        // Deltas 4,4,4,4,1 sum to 17 on a 4-bit total; delta 4 is still legal.
        do_reset(4'd0, "baseline_ovf");
        step(4'd4,  4'd4, 4'd4,  1'b0, 1'b0, "acc_4");
        step(4'd8,  4'd4, 4'd8,  1'b0, 1'b0, "acc_8");
        step(4'd12, 4'd4, 4'd12, 1'b0, 1'b0, "acc_12");
        step(4'd0,  4'd4, 4'd0,  1'b1, 1'b0, "acc_carry");
        step(4'd1,  4'd1, 4'd1,  1'b1, 1'b0, "acc_17");

        // Clear coincides with the accept of delta 2 (1 -> 3).
        drive(4'd3);
        exp_q.push_back(mk(1'b1, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, cyc + 32'd6));
        exp_name_q.push_back("clear_with_accept");
        repeat (5) @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        repeat (3) @(posedge clk);

        // Reset mid-operation while run = 1 for new code 3.
        do_reset(4'd2, "baseline_2");
        drive(4'd3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        check_now(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "async_reset_zero");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_now(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, "rebaseline_3");

        repeat (3) @(posedge clk);
        done = 1'b1;
    end
endmodule
